// File: rtl/modulo_pagamento_pkg.sv
// Shared definitions for the coffee-machine payment handshake: coin codes,
// coin values, payment state encoding and the controller's state codes.
package pkg_cafe;

  localparam int PRECO_PADRAO = 150;

  localparam logic [2:0] MOEDA_5   = 3'd0;
  localparam logic [2:0] MOEDA_10  = 3'd1;
  localparam logic [2:0] MOEDA_25  = 3'd2;
  localparam logic [2:0] MOEDA_50  = 3'd3;
  localparam logic [2:0] MOEDA_100 = 3'd4;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    COLETANDO  = 2'd1,
    FINALIZADO = 2'd2
  } estado_pag_t;

  // Controller-side state codes, kept here so both ends agree.
  localparam logic [2:0] CTRL_ESPERA    = 3'd0;
  localparam logic [2:0] CTRL_PAGAMENTO = 3'd1;
  localparam logic [2:0] CTRL_PREPARO   = 3'd2;
  localparam logic [2:0] CTRL_ENTREGA   = 3'd3;
  localparam logic [2:0] CTRL_ERRO      = 3'd4;

  function automatic logic moeda_ok(input logic [2:0] codigo);
    return codigo <= MOEDA_100;
  endfunction

  function automatic logic [8:0] valor_moeda(input logic [2:0] codigo);
    case (codigo)
      MOEDA_5:   valor_moeda = 9'd5;
      MOEDA_10:  valor_moeda = 9'd10;
      MOEDA_25:  valor_moeda = 9'd25;
      MOEDA_50:  valor_moeda = 9'd50;
      MOEDA_100: valor_moeda = 9'd100;
      default:   valor_moeda = 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/modulo_pagamento_contador.sv
// Inactivity counter: clear wins over enable; expira flags the enabled cycle
// in which the count would reach TIMEOUT_CICLOS.
module contador_inatividade #(
  parameter int TIMEOUT_CICLOS = 1000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expira
);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expira = en && !clr && (cnt == TIMEOUT_W'(TIMEOUT_CICLOS - 1));

endmodule

// File: rtl/modulo_pagamento.sv
// Payment unit: collects coins during a session, closes on confirm or on
// reaching the price, and expires the session after inactivity.
module modulo_pagamento
  import pkg_cafe::*;
#(
  parameter int PRECO          = PRECO_PADRAO,
  parameter int TIMEOUT_CICLOS = 1000,
  parameter int TIMEOUT_W      = 16,
  parameter bit AUTO_ENCERRA   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       INICIAR,
  input  logic       MOEDA_VALIDA,
  input  logic [2:0] MOEDA_CODIGO,
  input  logic       BOTAO_CONFIRMA,
  output logic       PAGO,
  output logic       ENCERRADO,
  output logic       TEMPO_ESGOTADO,
  output logic       REJEITADA,
  output logic [8:0] TOTAL,
  output logic [8:0] TROCO,
  output logic [8:0] DEVOLUCAO
);

  estado_pag_t estado;
  logic        pago_int;
  logic        moeda_aceita, fecha, pago_n, expira, cnt_clr, cnt_en;
  logic [8:0]  total_n;

  // A coin in the closing cycle is counted before the price comparison.
  assign moeda_aceita = MOEDA_VALIDA && moeda_ok(MOEDA_CODIGO);
  assign total_n      = moeda_aceita ? TOTAL + valor_moeda(MOEDA_CODIGO) : TOTAL;
  assign pago_n       = total_n >= 9'(PRECO);
  assign fecha        = BOTAO_CONFIRMA || (AUTO_ENCERRA && pago_n);

  assign cnt_clr = ((estado == OCIOSO) && INICIAR) ||
                   ((estado == COLETANDO) && moeda_aceita);
  assign cnt_en  = (estado == COLETANDO) && !moeda_aceita && !fecha;

  contador_inatividade #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS),
    .TIMEOUT_W     (TIMEOUT_W)
  ) u_contador (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .expira(expira)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado         <= OCIOSO;
      pago_int       <= 1'b0;
      PAGO           <= 1'b0;
      ENCERRADO      <= 1'b0;
      TEMPO_ESGOTADO <= 1'b0;
      REJEITADA      <= 1'b0;
      TOTAL          <= '0;
      TROCO          <= '0;
      DEVOLUCAO      <= '0;
    end else begin
      PAGO           <= 1'b0;
      ENCERRADO      <= 1'b0;
      TEMPO_ESGOTADO <= 1'b0;
      REJEITADA      <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (MOEDA_VALIDA) REJEITADA <= 1'b1;
          if (INICIAR) begin
            estado    <= COLETANDO;
            TOTAL     <= '0;
            TROCO     <= '0;
            DEVOLUCAO <= '0;
          end
        end
        COLETANDO: begin
          if (MOEDA_VALIDA && !moeda_aceita) REJEITADA <= 1'b1;
          TOTAL <= total_n;
          if (fecha) begin
            estado   <= FINALIZADO;
            pago_int <= pago_n;
            if (pago_n) TROCO     <= total_n - 9'(PRECO);
            else        DEVOLUCAO <= total_n;
          end else if (expira) begin
            estado         <= OCIOSO;
            TEMPO_ESGOTADO <= 1'b1;
            DEVOLUCAO      <= TOTAL;
            TOTAL          <= '0;
          end
        end
        FINALIZADO: begin
          ENCERRADO <= 1'b1;
          PAGO      <= pago_int;
          if (MOEDA_VALIDA) REJEITADA <= 1'b1;
          estado    <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_pagamento.sv
// Directed bench for modulo_pagamento with PRECO=150, TIMEOUT_CICLOS=20.
module tb_modulo_pagamento;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       INICIAR = 1'b0, MOEDA_VALIDA = 1'b0, BOTAO_CONFIRMA = 1'b0;
  logic [2:0] MOEDA_CODIGO = 3'd0;
  logic       PAGO, ENCERRADO, TEMPO_ESGOTADO, REJEITADA;
  logic [8:0] TOTAL, TROCO, DEVOLUCAO;

  int checks = 0;
  int errors = 0;

  modulo_pagamento #(
    .PRECO(150), .TIMEOUT_CICLOS(20), .TIMEOUT_W(8), .AUTO_ENCERRA(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .INICIAR(INICIAR), .MOEDA_VALIDA(MOEDA_VALIDA),
    .MOEDA_CODIGO(MOEDA_CODIGO), .BOTAO_CONFIRMA(BOTAO_CONFIRMA),
    .PAGO(PAGO), .ENCERRADO(ENCERRADO), .TEMPO_ESGOTADO(TEMPO_ESGOTADO),
    .REJEITADA(REJEITADA), .TOTAL(TOTAL), .TROCO(TROCO), .DEVOLUCAO(DEVOLUCAO)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nome, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nome, got, exp);
    end
  endtask

  task automatic moeda(input logic [2:0] c);
    MOEDA_VALIDA = 1'b1; MOEDA_CODIGO = c;
    tick();
    MOEDA_VALIDA = 1'b0;
  endtask

  task automatic iniciar();
    INICIAR = 1'b1;
    tick();
    INICIAR = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    chk("reset_total", TOTAL, 0);
    chk("reset_flags", {PAGO, ENCERRADO, TEMPO_ESGOTADO, REJEITADA}, 0);
    chk("reset_troco_dev", {TROCO, DEVOLUCAO}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_exact();
    iniciar();
    chk("exact_start_total", TOTAL, 0);
    moeda(3'd4);
    chk("exact_total_100", TOTAL, 100);
    moeda(3'd3);
    chk("exact_total_150", TOTAL, 150);
    chk("exact_no_enc_yet", ENCERRADO, 0);
    tick();
    chk("exact_enc", ENCERRADO, 1);
    chk("exact_pago", PAGO, 1);
    chk("exact_troco", TROCO, 0);
    tick();
    chk("exact_enc_drop", ENCERRADO, 0);
    chk("exact_pago_drop", PAGO, 0);
  endtask

  task automatic test_overpay();
    iniciar();
    moeda(3'd4); moeda(3'd2);
    chk("over_total_125", TOTAL, 125);
    moeda(3'd4);
    chk("over_total_225", TOTAL, 225);
    tick();
    chk("over_enc", ENCERRADO, 1);
    chk("over_pago", PAGO, 1);
    chk("over_troco", TROCO, 75);
    chk("over_dev", DEVOLUCAO, 0);
    moeda(3'd0);
    chk("over_troco_hold", TROCO, 75);
  endtask

  task automatic test_underpaid();
    iniciar();
    chk("under_troco_cleared", TROCO, 0);
    moeda(3'd2); moeda(3'd2);
    BOTAO_CONFIRMA = 1'b1;
    moeda(3'd1);
    BOTAO_CONFIRMA = 1'b0;
    chk("under_total_60", TOTAL, 60);
    moeda(3'd4);
    chk("under_enc", ENCERRADO, 1);
    chk("under_pago", PAGO, 0);
    chk("under_dev", DEVOLUCAO, 60);
    chk("under_finalizado_rej", REJEITADA, 1);
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    bit enc_seen = 0;
    iniciar();
    tick(); tick();
    moeda(3'd1);
    chk("to_total_10", TOTAL, 10);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ENCERRADO) enc_seen = 1;
      if (TEMPO_ESGOTADO) begin n = i; break; end
    end
    chk("to_latency", n, 20);
    chk("to_dev", DEVOLUCAO, 10);
    chk("to_total_zero", TOTAL, 0);
    chk("to_no_enc", enc_seen, 0);
    tick();
    chk("to_pulse_drop", TEMPO_ESGOTADO, 0);
    moeda(3'd1);
    chk("to_ocioso_rej", REJEITADA, 1);
    tick();
  endtask

  task automatic test_rejection();
    int n = 0;
    iniciar();
    for (int i = 0; i < 4; i++) tick();
    moeda(3'd6);
    chk("rej_pulse", REJEITADA, 1);
    chk("rej_total", TOTAL, 0);
    tick();
    chk("rej_pulse_drop", REJEITADA, 0);
    // 6 edges since INICIAR so far; expiry still due at edge 20
    for (int i = 7; i <= 40; i++) begin
      tick();
      if (TEMPO_ESGOTADO) begin n = i; break; end
    end
    chk("rej_expiry_ref", n, 20);
    moeda(3'd0);
    chk("rej_ocioso", REJEITADA, 1);
    chk("rej_ocioso_total", TOTAL, 0);
    tick();
  endtask

  task automatic test_confirm_vs_expiry();
    iniciar();
    for (int i = 0; i < 19; i++) tick();
    BOTAO_CONFIRMA = 1'b1;
    tick();
    BOTAO_CONFIRMA = 1'b0;
    chk("cve_no_timeout", TEMPO_ESGOTADO, 0);
    tick();
    chk("cve_enc", ENCERRADO, 1);
    chk("cve_pago", PAGO, 0);
    tick();
  endtask

  task automatic test_async_reset();
    iniciar();
    moeda(3'd4); moeda(3'd2);
    chk("ar_total_125", TOTAL, 125);
    #2 rst = 1'b1;
    #1;
    chk("ar_total_zero", TOTAL, 0);
    chk("ar_outs_zero", {PAGO, ENCERRADO, TEMPO_ESGOTADO, REJEITADA, TROCO, DEVOLUCAO}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_no_pulses", {ENCERRADO, TEMPO_ESGOTADO, REJEITADA}, 0);
    iniciar();
    moeda(3'd4);
    chk("ar_clean_session", TOTAL, 100);
  endtask

  initial begin
    test_reset();
    test_exact();
    test_overpay();
    test_underpaid();
    test_timeout();
    test_rejection();
    test_confirm_vs_expiry();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/modulo_pagamento.md
Name: modulo_pagamento

Overview:
Payment unit on the far end of the coffee-machine payment handshake. The controller starts a payment session with a start pulse. This block accumulates coin pulses, then reports the outcome on PAGO/ENCERRADO, which the controller samples while in its payment state. It also raises TEMPO_ESGOTADO on inactivity and reports change/refund amounts for the coin dispenser.

Parameters:
PRECO, 150, drink price in cents; legal range 5..400, multiple of 5
TIMEOUT_CICLOS, 1000, idle cycles in a session before expiry; must be >= 2
TIMEOUT_W, 16, width of the inactivity counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CICLOS
AUTO_ENCERRA, 1, 1 = session closes automatically once TOTAL >= PRECO

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
INICIAR  in  1  one-cycle session start from the controller
MOEDA_VALIDA  in  1  one-cycle coin-inserted strobe
MOEDA_CODIGO  in  3  coin code: 0=5, 1=10, 2=25, 3=50, 4=100 cents; 5..7 invalid
BOTAO_CONFIRMA  in  1  user ends payment
PAGO  out  1  valid only while ENCERRADO=1; 1 = TOTAL >= PRECO
ENCERRADO  out  1  one-cycle session-closed pulse
TEMPO_ESGOTADO  out  1  one-cycle inactivity-expiry pulse
REJEITADA  out  1  one-cycle pulse: coin returned unaccepted
TOTAL  out  9  running accumulated value in cents
TROCO  out  9  change owed after a paid session
DEVOLUCAO  out  9  refund owed after an unpaid or expired session

Behaviour:
- Reset (async, rst=1): state OCIOSO; all outputs 0; counter 0.
- Registered outputs: every output is registered. Pulses last exactly one clk cycle.
- Coin values: from a fixed lookup. TOTAL is 9 bits. PRECO <= 400 guarantees TOTAL <= PRECO+95 <= 495, so TOTAL never overflows.
- States: OCIOSO, COLETANDO, FINALIZADO.
- OCIOSO:
  - INICIAR -> COLETANDO; TOTAL, TROCO, DEVOLUCAO and counter cleared.
  - Any MOEDA_VALIDA in this state gives REJEITADA=1 on the next cycle.
- COLETANDO, per cycle, evaluated in this order:
  1. Coin:
     - Valid coin: TOTAL_n = TOTAL + value; counter cleared.
     - Invalid code: REJEITADA pulse; TOTAL unchanged; counter keeps counting.
  2. Close condition: BOTAO_CONFIRMA=1, or (AUTO_ENCERRA=1 and TOTAL_n >= PRECO).
     - Effect: -> FINALIZADO.
     - Paid (TOTAL_n >= PRECO): PAGO_n=1, TROCO_n = TOTAL_n - PRECO.
     - Unpaid: PAGO_n=0, DEVOLUCAO_n = TOTAL_n.
     - A coin arriving in the same cycle as confirm is counted before the comparison.
  3. Otherwise the counter increments. When it would reach TIMEOUT_CICLOS:
     - TEMPO_ESGOTADO pulse; DEVOLUCAO = TOTAL; TOTAL = 0; -> OCIOSO.
     - PAGO and ENCERRADO stay 0.
  - INICIAR is ignored in this state.
- FINALIZADO: lasts exactly one cycle.
  - ENCERRADO=1 and PAGO carries the result, then -> OCIOSO.
  - Coins arriving in this state are rejected.
  - TROCO and DEVOLUCAO hold until the next INICIAR or reset.
- Expiry timing: TEMPO_ESGOTADO asserts TIMEOUT_CICLOS cycles after the last accepted coin, or after the cycle where the state became COLETANDO.
- Confirm vs expiry: if confirm occurs in the expiry cycle, confirm wins and the session closes normally.
- Reset mid-session: returns to OCIOSO, clears everything, no pulses emitted.

Decomposition:
- Shared package pkg_cafe:
  - coin code constants and the coin-to-cents function
  - payment state encoding (2 bits)
  - PRECO default
  - the controller's 3-bit state constants, so both ends share one source
- One sub-module, contador_inatividade: counter with clear/enable and an expiry flag, parameterised by TIMEOUT_CICLOS and TIMEOUT_W.

Test Plan (PRECO=150, TIMEOUT_CICLOS=20, AUTO_ENCERRA=1):
- Exact payment: INICIAR; coins code 4 then code 3 -> TOTAL 100 then 150; next cycle ENCERRADO=1, PAGO=1, TROCO=0; one cycle later ENCERRADO=0.
- Overpayment: coins 4, 2, 4 -> TOTAL 225; ENCERRADO=1, PAGO=1, TROCO=75.
- Underpaid confirm: coins 2, 2; then MOEDA_VALIDA code 1 in the same cycle as BOTAO_CONFIRMA -> TOTAL 60; ENCERRADO=1, PAGO=0, DEVOLUCAO=60.
- Timeout: INICIAR; coin code 1 at cycle 3; nothing further -> TEMPO_ESGOTADO pulse exactly 20 cycles after acceptance; DEVOLUCAO=10; ENCERRADO never 1; state OCIOSO.
- Rejection: code 6 during COLETANDO -> REJEITADA pulse, TOTAL unchanged, expiry still at 20 cycles from the previous reference point; code 0 in OCIOSO -> REJEITADA, TOTAL stays 0.
- Async reset: after TOTAL=125, assert rst mid-cycle -> outputs zero immediately without waiting for clk; after release, INICIAR starts a clean session from TOTAL=0.
